// File: rtl/byte_packer.sv
// Byte packer: compacts the enabled byte lanes of each 32-bit sample into a
// continuous byte stream and emits it as 32-bit memory words, with a
// partial (keep-masked) final word at the end of each capture.
module byte_packer #(
    parameter int SDW = 32,
    parameter int MDW = 32,
    parameter int MKW = MDW / 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ctl_clr,
    input  logic [3:0]     cfg_mask,
    output logic           sti_tready,
    input  logic           sti_tvalid,
    input  logic           sti_tlast,
    input  logic [SDW-1:0] sti_tdata,
    input  logic           sto_tready,
    output logic           sto_tvalid,
    output logic           sto_tlast,
    output logic [MKW-1:0] sto_tkeep,
    output logic [MDW-1:0] sto_tdata
);

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    state_t         state_q, state_d;
    logic [1:0]     fill_q, fill_d;
    logic [23:0]    res_q, res_d;
    logic [3:0]     mask_q, mask_d;
    logic           vld_q, vld_d;
    logic           last_q, last_d;
    logic [MKW-1:0] keep_q, keep_d;
    logic [MDW-1:0] data_q, data_d;

    logic           out_free;
    logic           accept;
    logic [2:0]     n_bytes;
    logic [2:0]     total;
    logic [2:0]     rem;
    logic [31:0]    packed_bytes;
    logic [55:0]    acc;

    // Move the enabled lanes down to the low bytes, preserving lane order.
    function automatic logic [31:0] compact(input logic [3:0] m, input logic [31:0] d);
        logic [31:0] r;
        int unsigned c;
        r = '0;
        c = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                r[8*c +: 8] = d[8*i +: 8];
                c++;
            end
        end
        return r;
    endfunction

    function automatic logic [2:0] popcnt(input logic [3:0] m);
        return {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
    endfunction

    // Low 'cnt' lanes set; cnt of 0 gives an empty keep.
    function automatic logic [3:0] keep_of(input logic [2:0] cnt);
        logic [3:0] k;
        for (int i = 0; i < 4; i++) k[i] = (3'(i) < cnt);
        return k;
    endfunction

    assign out_free     = !vld_q || sto_tready;
    assign sti_tready   = (state_q == S_RUN) && out_free;
    assign accept       = sti_tvalid && sti_tready && !ctl_clr;
    assign n_bytes      = popcnt(mask_q);
    assign total        = {1'b0, fill_q} + n_bytes;
    assign rem          = total - 3'd4;
    assign packed_bytes = compact(mask_q, sti_tdata[31:0]);
    // Residual bytes sit below 'fill'; new bytes are appended above them.
    // Bytes above fill+N stay zero, which keeps unused output lanes at 0.
    assign acc          = {32'b0, res_q} | ({24'b0, packed_bytes} << {fill_q, 3'b000});

    // State, accumulator and output register update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            fill_q  <= '0;
            res_q   <= '0;
            mask_q  <= 4'hF;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            keep_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            res_q   <= res_d;
            mask_q  <= mask_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            keep_q  <= keep_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic: clear wins, then flush of residual bytes, then sample intake.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        res_d   = res_q;
        mask_d  = mask_q;
        vld_d   = vld_q;
        last_d  = last_q;
        keep_d  = keep_q;
        data_d  = data_q;

        if (vld_q && sto_tready) vld_d = 1'b0;

        if (ctl_clr) begin
            mask_d  = cfg_mask;
            fill_d  = '0;
            res_d   = '0;
            state_d = S_RUN;
            vld_d   = 1'b0;
            last_d  = 1'b0;
        end else if (state_q == S_FLUSH) begin
            if (out_free) begin
                vld_d   = 1'b1;
                last_d  = 1'b1;
                keep_d  = keep_of({1'b0, fill_q});
                data_d  = {8'h00, res_q};
                fill_d  = '0;
                res_d   = '0;
                state_d = S_RUN;
            end
        end else if (accept) begin
            if (total >= 3'd4) begin
                vld_d  = 1'b1;
                last_d = 1'b0;
                keep_d = 4'hF;
                data_d = acc[31:0];
                res_d  = acc[55:32];
                fill_d = rem[1:0];
                if (sti_tlast) begin
                    if (rem == 3'd0) last_d = 1'b1;
                    else             state_d = S_FLUSH;
                end
            end else if (sti_tlast) begin
                vld_d  = 1'b1;
                last_d = 1'b1;
                keep_d = keep_of(total);
                data_d = acc[31:0];
                fill_d = '0;
                res_d  = '0;
            end else begin
                fill_d = total[1:0];
                res_d  = acc[23:0];
            end
        end
    end

    assign sto_tvalid = vld_q;
    assign sto_tlast  = last_q;
    assign sto_tkeep  = keep_q;
    assign sto_tdata  = data_q;

endmodule
